// File: rtl/trena_scheduler.sv
// -----------------------------------------------------------------------------
// trena_scheduler
//
// Sequences one distance measurement: start the sensor interface, wait for its
// BCD result, latch it, start the serial transmitter and wait for it to finish.
// In continuous mode a new measurement starts every INTERVALO cycles, measured
// from one DISPARA entry to the next, so slow responses do not stretch the
// period unless they outlast it.
//
// Parameters:
//   INTERVALO - cycles between measurement starts in continuous mode
//   TIMEOUT   - cycles to wait for medida_pronta / tx_pronto (timeout build only)
//
// Optional feature (macro TRENA_TIMEOUT_EN):
//   defined   - a wait counter aborts ESPERA_MEDIDA / ESPERA_TX after TIMEOUT
//               cycles into FALHA, which sets the sticky erro flag
//   undefined - no wait counter, no FALHA state, erro tied to 0, waits forever
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   mensurar      in   one-cycle request for a single measurement
//   continuo      in   level, 1 = periodic measurement
//   medida_pronta in   sensor done pulse
//   medida[11:0]  in   3-digit BCD distance, valid with medida_pronta
//   tx_pronto     in   transmitter done pulse
//   sensor_inicio out  one-cycle start pulse to the sensor (high in DISPARA)
//   tx_inicio     out  one-cycle start pulse to the transmitter (high in TRANSMITE)
//   tx_dados[11:0]out  latched measurement
//   ocupado       out  high in every state except OCIOSO
//   erro          out  sticky timeout flag
//   db_estado[3:0]out  current state code for the debug display
// -----------------------------------------------------------------------------
module trena_scheduler #(
    parameter int INTERVALO = 12500000,
    parameter int TIMEOUT   = 1500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mensurar,
    input  logic        continuo,
    input  logic        medida_pronta,
    input  logic [11:0] medida,
    input  logic        tx_pronto,
    output logic        sensor_inicio,
    output logic        tx_inicio,
    output logic [11:0] tx_dados,
    output logic        ocupado,
    output logic        erro,
    output logic [3:0]  db_estado
);

    // Reject configurations that would make the counters meaningless.
    if (INTERVALO < 1 || TIMEOUT < 1) begin : g_param_check
        $error("trena_scheduler: INTERVALO and TIMEOUT must be at least 1");
    end

    localparam int INT_W = $clog2(INTERVALO + 1);
    localparam logic [INT_W-1:0] INT_LAST = INT_W'(INTERVALO - 1);

    typedef enum logic [3:0] {
        ST_OCIOSO        = 4'h0,
        ST_DISPARA       = 4'h1,
        ST_ESPERA_MEDIDA = 4'h2,
        ST_ARMAZENA      = 4'h3,
        ST_TRANSMITE     = 4'h4,
        ST_ESPERA_TX     = 4'h5,
        ST_INTERVALO     = 4'h6
`ifdef TRENA_TIMEOUT_EN
        ,
        ST_FALHA         = 4'hF
`endif
    } state_t;

    state_t           r_state;
    logic             r_sensor_inicio;
    logic             r_tx_inicio;
    logic [11:0]      r_tx_dados;
    logic [INT_W-1:0] r_cnt_int;    // cycles since the last DISPARA entry
    logic             w_int_done;

`ifdef TRENA_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    logic [WAIT_W-1:0] r_cnt_wait;  // cycles spent in the current wait state
    logic              r_erro;
`endif

    // The interval counter saturates at INTERVALO-1, so "elapsed" stays true
    // however long a slow transmitter holds us in ESPERA_TX.
    assign w_int_done = (r_cnt_int == INT_LAST);

    // Pulses are set on the transition into their state, so each one lines up
    // with exactly one cycle of DISPARA / TRANSMITE and they can never overlap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_OCIOSO;
            r_sensor_inicio <= 1'b0;
            r_tx_inicio     <= 1'b0;
            r_tx_dados      <= 12'h000;
            r_cnt_int       <= '0;
`ifdef TRENA_TIMEOUT_EN
            r_cnt_wait      <= '0;
            r_erro          <= 1'b0;
`endif
        end else begin
            r_sensor_inicio <= 1'b0;
            r_tx_inicio     <= 1'b0;
            if (!w_int_done) begin
                r_cnt_int <= r_cnt_int + INT_W'(1);
            end

            case (r_state)
                ST_OCIOSO: begin
                    if (mensurar || continuo) begin
                        r_state         <= ST_DISPARA;
                        r_sensor_inicio <= 1'b1;
                        r_cnt_int       <= '0;
                    end
                end
                ST_DISPARA: begin
                    r_state <= ST_ESPERA_MEDIDA;
`ifdef TRENA_TIMEOUT_EN
                    r_cnt_wait <= '0;
`endif
                end
                ST_ESPERA_MEDIDA: begin
                    if (medida_pronta) begin
                        r_tx_dados <= medida;
                        r_state    <= ST_ARMAZENA;
                    end
`ifdef TRENA_TIMEOUT_EN
                    else if (r_cnt_wait == WAIT_LAST) begin
                        r_state <= ST_FALHA;
                        r_erro  <= 1'b1;
                    end else begin
                        r_cnt_wait <= r_cnt_wait + WAIT_W'(1);
                    end
`endif
                end
                ST_ARMAZENA: begin
                    r_state     <= ST_TRANSMITE;
                    r_tx_inicio <= 1'b1;
                end
                ST_TRANSMITE: begin
                    r_state <= ST_ESPERA_TX;
`ifdef TRENA_TIMEOUT_EN
                    r_cnt_wait <= '0;
`endif
                end
                ST_ESPERA_TX: begin
                    if (tx_pronto) begin
                        if (!continuo) begin
                            r_state <= ST_OCIOSO;
                        end else if (w_int_done) begin
                            // Transmitter outlasted the period: restart at once.
                            r_state         <= ST_DISPARA;
                            r_sensor_inicio <= 1'b1;
                            r_cnt_int       <= '0;
                        end else begin
                            r_state <= ST_INTERVALO;
                        end
                    end
`ifdef TRENA_TIMEOUT_EN
                    else if (r_cnt_wait == WAIT_LAST) begin
                        r_state <= ST_FALHA;
                        r_erro  <= 1'b1;
                    end else begin
                        r_cnt_wait <= r_cnt_wait + WAIT_W'(1);
                    end
`endif
                end
                ST_INTERVALO: begin
                    if (!continuo) begin
                        r_state <= ST_OCIOSO;
                    end else if (w_int_done) begin
                        r_state         <= ST_DISPARA;
                        r_sensor_inicio <= 1'b1;
                        r_cnt_int       <= '0;
                    end
                end
`ifdef TRENA_TIMEOUT_EN
                ST_FALHA: begin
                    r_state <= continuo ? ST_INTERVALO : ST_OCIOSO;
                end
`endif
                default: begin
                    r_state <= ST_OCIOSO;
                end
            endcase
        end
    end

    assign sensor_inicio = r_sensor_inicio;
    assign tx_inicio     = r_tx_inicio;
    assign tx_dados      = r_tx_dados;
    assign ocupado       = (r_state != ST_OCIOSO);
    assign db_estado     = r_state;
`ifdef TRENA_TIMEOUT_EN
    assign erro          = r_erro;
`else
    assign erro          = 1'b0;
`endif

endmodule

// File: tb/tb_trena_scheduler.sv
// -----------------------------------------------------------------------------
// tb_trena_scheduler
//
// Directed bench for trena_scheduler with INTERVALO=200 and TIMEOUT=100.
// Inputs change and outputs are sampled 1 ns after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_trena_scheduler;

    localparam int P_INT = 200;
    localparam int P_TO  = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mensurar = 1'b0;
    logic        continuo = 1'b0;
    logic        medida_pronta = 1'b0;
    logic [11:0] medida = 12'h000;
    logic        tx_pronto = 1'b0;
    logic        sensor_inicio;
    logic        tx_inicio;
    logic [11:0] tx_dados;
    logic        ocupado;
    logic        erro;
    logic [3:0]  db_estado;

    int checks   = 0;
    int failures = 0;

    // Pulse monitor: cycle stamps of sensor_inicio, pulse counts, overlap count.
    int cyc      = 0;
    int s_cnt    = 0;
    int t_cnt    = 0;
    int both_cnt = 0;
    int s_times [0:63];

    trena_scheduler #(
        .INTERVALO (P_INT),
        .TIMEOUT   (P_TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mensurar      (mensurar),
        .continuo      (continuo),
        .medida_pronta (medida_pronta),
        .medida        (medida),
        .tx_pronto     (tx_pronto),
        .sensor_inicio (sensor_inicio),
        .tx_inicio     (tx_inicio),
        .tx_dados      (tx_dados),
        .ocupado       (ocupado),
        .erro          (erro),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (sensor_inicio) begin
            if (s_cnt < 64) s_times[s_cnt] <= cyc;
            s_cnt <= s_cnt + 1;
        end
        if (tx_inicio) t_cnt <= t_cnt + 1;
        if (sensor_inicio && tx_inicio) both_cnt <= both_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int n = 0;
        while (db_estado != s && n < budget) begin
            step(1);
            n++;
        end
        check_eq(tag, db_estado, s);
    endtask

    task automatic pulse_mensurar();
        mensurar = 1'b1;
        step(1);
        mensurar = 1'b0;
    endtask

    task automatic pulse_medida(input logic [11:0] v);
        medida        = v;
        medida_pronta = 1'b1;
        step(1);
        medida_pronta = 1'b0;
    endtask

    task automatic pulse_tx();
        tx_pronto = 1'b1;
        step(1);
        tx_pronto = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, tb0, t1;

        // ---------------- reset state ----------------
        step(2);
        check_eq("rst_state",   db_estado, 4'h0);
        check_eq("rst_ocupado", ocupado, 1'b0);
        check_eq("rst_sensor",  sensor_inicio, 1'b0);
        check_eq("rst_tx",      tx_inicio, 1'b0);
        check_eq("rst_dados",   tx_dados, 12'h000);
        check_eq("rst_erro",    erro, 1'b0);
        reset = 1'b1;
        step(2);
        check_eq("idle_state",  db_estado, 4'h0);
        $display("[tb] reset state checked");

        // ---------------- single shot ----------------
        sb = s_cnt; tb0 = t_cnt;
        pulse_mensurar();
        check_eq("ss_dispara", db_estado, 4'h1);
        check_eq("ss_sensor",  sensor_inicio, 1'b1);
        check_eq("ss_ocupado", ocupado, 1'b1);
        step(1);
        check_eq("ss_espera",  db_estado, 4'h2);
        check_eq("ss_sensor_off", sensor_inicio, 1'b0);
        step(9);
        pulse_medida(12'h123);
        check_eq("ss_armazena", db_estado, 4'h3);
        check_eq("ss_dados",    tx_dados, 12'h123);
        step(1);
        check_eq("ss_transmite", db_estado, 4'h4);
        check_eq("ss_tx_inicio", tx_inicio, 1'b1);
        step(1);
        check_eq("ss_espera_tx", db_estado, 4'h5);
        step(19);
        pulse_tx();
        check_eq("ss_done_state",   db_estado, 4'h0);
        check_eq("ss_done_ocupado", ocupado, 1'b0);
        check_eq("ss_sensor_count", s_cnt - sb, 1);
        check_eq("ss_tx_count",     t_cnt - tb0, 1);
        $display("[tb] single shot: tx_dados=%03h", tx_dados);

        // ---------------- ignored stimulus ----------------
        pulse_medida(12'h456);
        check_eq("ign_med_state", db_estado, 4'h0);
        check_eq("ign_med_dados", tx_dados, 12'h123);
        pulse_tx();
        check_eq("ign_tx_state",  db_estado, 4'h0);
        sb = s_cnt;
        pulse_mensurar();
        step(1);
        check_eq("ign_espera",     db_estado, 4'h2);
        pulse_mensurar();
        check_eq("ign_mens_state", db_estado, 4'h2);
        check_eq("ign_mens_count", s_cnt - sb, 1);
        check_eq("ign_mens_dados", tx_dados, 12'h123);
        pulse_medida(12'h789);
        check_eq("ign_new_dados",  tx_dados, 12'h789);
        wait_state(4'h5, 5, "ign_wait_tx");
        pulse_tx();
        check_eq("ign_done", db_estado, 4'h0);
        $display("[tb] ignored stimulus: tx_dados=%03h", tx_dados);

        // ---------------- continuous mode ----------------
        sb = s_cnt;
        continuo = 1'b1;
        for (int p = 0; p < 6; p++) begin
            wait_state(4'h2, 300, "cont_wait_med");
            if (p == 5) continuo = 1'b0;
            pulse_medida(12'h100 + 12'(p));
            wait_state(4'h5, 10, "cont_wait_tx");
            pulse_tx();
            check_eq("cont_after_tx", db_estado, (p == 5) ? 4'h0 : 4'h6);
        end
        for (int k = 0; k < 5; k++) begin
            check_eq("cont_period", s_times[sb + k + 1] - s_times[sb + k], P_INT);
        end
        step(300);
        check_eq("cont_pulses", s_cnt - sb, 6);
        check_eq("cont_idle",   db_estado, 4'h0);
        $display("[tb] continuous: %0d sensor pulses", s_cnt - sb);

        // ---------------- late transmitter ----------------
        sb = s_cnt;
        continuo = 1'b1;
        wait_state(4'h2, 5, "late_wait_med");
        pulse_medida(12'h321);
        wait_state(4'h4, 5, "late_transmite");
        step(249);
        check_eq("late_hold", db_estado, 4'h5);
        pulse_tx();
        check_eq("late_dispara", db_estado, 4'h1);
        check_eq("late_sensor",  sensor_inicio, 1'b1);
        check_eq("late_count",   s_cnt - sb, 2);
        continuo = 1'b0;
        wait_state(4'h2, 5, "late_wait_med2");
        pulse_medida(12'h322);
        wait_state(4'h5, 5, "late_wait_tx2");
        pulse_tx();
        check_eq("late_done", db_estado, 4'h0);
        $display("[tb] late transmitter handled");

        // ---------------- reset in ESPERA_TX ----------------
        pulse_mensurar();
        wait_state(4'h2, 5, "rmid_wait_med");
        pulse_medida(12'h654);
        wait_state(4'h5, 5, "rmid_wait_tx");
        t1 = t_cnt;
        reset = 1'b0;
        #1;
        check_eq("rmid_state",   db_estado, 4'h0);
        check_eq("rmid_ocupado", ocupado, 1'b0);
        check_eq("rmid_dados",   tx_dados, 12'h000);
        check_eq("rmid_sensor",  sensor_inicio, 1'b0);
        check_eq("rmid_tx",      tx_inicio, 1'b0);
        check_eq("rmid_erro",    erro, 1'b0);
        step(3);
        reset = 1'b1;
        step(5);
        check_eq("rmid_after_state", db_estado, 4'h0);
        check_eq("rmid_no_tx",       t_cnt - t1, 0);
        pulse_tx();
        check_eq("rmid_spur_state",  db_estado, 4'h0);
        check_eq("rmid_spur_dados",  tx_dados, 12'h000);
        check_eq("rmid_spur_tx",     t_cnt - t1, 0);
        $display("[tb] reset during transmission handled");

        // ---------------- timeout / indefinite wait ----------------
`ifdef TRENA_TIMEOUT_EN
        pulse_mensurar();
        step(1);
        check_eq("to_espera", db_estado, 4'h2);
        step(P_TO - 1);
        check_eq("to_before", db_estado, 4'h2);
        step(1);
        check_eq("to_falha",  db_estado, 4'hF);
        check_eq("to_erro",   erro, 1'b1);
        step(1);
        check_eq("to_ocioso", db_estado, 4'h0);
        step(5);
        check_eq("to_erro_held", erro, 1'b1);
        $display("[tb] timeout reached FALHA");
`else
        pulse_mensurar();
        step(1);
        step(150);
        check_eq("nto_still_wait", db_estado, 4'h2);
        check_eq("nto_erro",       erro, 1'b0);
        pulse_medida(12'h999);
        wait_state(4'h5, 5, "nto_wait_tx");
        pulse_tx();
        check_eq("nto_done",  db_estado, 4'h0);
        check_eq("nto_dados", tx_dados, 12'h999);
        $display("[tb] indefinite wait completed");
`endif

        check_eq("pulse_overlap", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
